// File: rtl/udp_inbound_chain_rx.sv
// Terminating receiver for the daisy-chain UDP protocol: checks the version word,
// latches the hop count, and re-emits the payload as a framed stream with frame counters.
module udp_inbound_chain_rx #(
    parameter int MAX_PAYLOAD = 1472,
    parameter int CNT_W       = 16
) (
    input  logic             c,
    input  logic             rst,
    input  logic [7:0]       rxd,
    input  logic             rxdv,
    output logic [15:0]      hop_count,
    output logic             hop_count_valid,
    output logic [7:0]       payload_d,
    output logic             payload_dv,
    output logic             payload_last,
    output logic             payload_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int BC_W = $clog2(MAX_PAYLOAD + 1);
    localparam logic [BC_W-1:0] MAX_CNT = BC_W'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, VER_HI, HOP_LO, HOP_HI, PAYLOAD, DISCARD} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      hop_lo_reg, hop_lo_next;
    logic [7:0]      hold_reg, hold_next;
    logic            hold_full_reg, hold_full_next;
    logic [BC_W-1:0] count_reg, count_next;
    logic [15:0]     hop_count_next;
    logic            hop_count_valid_next;
    logic [7:0]      payload_d_next;
    logic            payload_dv_next, payload_last_next, payload_err_next;
    logic            good_inc, drop_inc;

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            hop_lo_reg      <= '0;
            hold_reg        <= '0;
            hold_full_reg   <= 1'b0;
            count_reg       <= '0;
            hop_count       <= '0;
            hop_count_valid <= 1'b0;
            payload_d       <= '0;
            payload_dv      <= 1'b0;
            payload_last    <= 1'b0;
            payload_err     <= 1'b0;
            good_cnt        <= '0;
            drop_cnt        <= '0;
        end else begin
            state_reg       <= state_next;
            hop_lo_reg      <= hop_lo_next;
            hold_reg        <= hold_next;
            hold_full_reg   <= hold_full_next;
            count_reg       <= count_next;
            hop_count       <= hop_count_next;
            hop_count_valid <= hop_count_valid_next;
            payload_d       <= payload_d_next;
            payload_dv      <= payload_dv_next;
            payload_last    <= payload_last_next;
            payload_err     <= payload_err_next;
            if (good_inc && !(&good_cnt))
                good_cnt <= good_cnt + 1'b1;
            if (drop_inc && !(&drop_cnt))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next           = state_reg;
        hop_lo_next          = hop_lo_reg;
        hold_next            = hold_reg;
        hold_full_next       = hold_full_reg;
        count_next           = count_reg;
        hop_count_next       = hop_count;
        hop_count_valid_next = 1'b0;
        payload_d_next       = payload_d;
        payload_dv_next      = 1'b0;
        payload_last_next    = 1'b0;
        payload_err_next     = 1'b0;
        good_inc             = 1'b0;
        drop_inc             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rxdv) begin
                    if (rxd == 8'h21) begin
                        state_next = VER_HI;
                    end else begin
                        state_next = DISCARD;
                        drop_inc   = 1'b1;
                    end
                end
            end
            VER_HI: begin
                if (rxdv && rxd == 8'h43) begin
                    state_next = HOP_LO;
                end else begin
                    state_next = rxdv ? DISCARD : IDLE;
                    drop_inc   = 1'b1;
                end
            end
            HOP_LO: begin
                if (rxdv) begin
                    hop_lo_next = rxd;
                    state_next  = HOP_HI;
                end else begin
                    state_next = IDLE;
                    drop_inc   = 1'b1;
                end
            end
            HOP_HI: begin
                if (rxdv) begin
                    hop_count_next       = {rxd, hop_lo_reg};
                    hop_count_valid_next = 1'b1;
                    count_next           = '0;
                    hold_full_next       = 1'b0;
                    state_next           = PAYLOAD;
                end else begin
                    state_next = IDLE;
                    drop_inc   = 1'b1;
                end
            end
            PAYLOAD: begin
                // One-byte hold lets the final byte carry last once rxdv drops.
                if (rxdv && count_reg < MAX_CNT) begin
                    payload_dv_next = hold_full_reg;
                    payload_d_next  = hold_full_reg ? hold_reg : payload_d;
                    hold_next       = rxd;
                    hold_full_next  = 1'b1;
                    count_next      = count_reg + 1'b1;
                end else if (rxdv) begin
                    payload_dv_next   = hold_full_reg;
                    payload_d_next    = hold_full_reg ? hold_reg : payload_d;
                    payload_last_next = hold_full_reg;
                    payload_err_next  = hold_full_reg;
                    hold_full_next    = 1'b0;
                    drop_inc          = 1'b1;
                    state_next        = DISCARD;
                end else begin
                    payload_dv_next   = hold_full_reg;
                    payload_d_next    = hold_full_reg ? hold_reg : payload_d;
                    payload_last_next = hold_full_reg;
                    hold_full_next    = 1'b0;
                    good_inc          = 1'b1;
                    state_next        = IDLE;
                end
            end
            DISCARD: begin
                if (!rxdv)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_udp_inbound_chain_rx.sv
// Randomized bench for udp_inbound_chain_rx: frames are classified by a byte-list model
// that predicts every output beat with its exact cycle, plus counters and hop count.
module tb_udp_inbound_chain_rx;
    localparam int MAXP = 6;
    localparam int CW   = 3;

    logic          c = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rxd = 8'h00;
    logic          rxdv = 1'b0;
    logic [15:0]   hop_count;
    logic          hop_count_valid;
    logic [7:0]    payload_d;
    logic          payload_dv, payload_last, payload_err;
    logic [CW-1:0] good_cnt, drop_cnt;

    udp_inbound_chain_rx #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
        .c(c), .rst(rst), .rxd(rxd), .rxdv(rxdv),
        .hop_count(hop_count), .hop_count_valid(hop_count_valid),
        .payload_d(payload_d), .payload_dv(payload_dv),
        .payload_last(payload_last), .payload_err(payload_err),
        .good_cnt(good_cnt), .drop_cnt(drop_cnt)
    );

    always #5 c = ~c;

    int edges = 0;
    always @(posedge c) edges <= edges + 1;

    typedef struct { int stamp; logic [7:0] d; logic last; logic err; } pay_t;
    typedef struct { int stamp; logic [15:0] v; } hop_t;
    pay_t pq[$];
    hop_t hq[$];

    int          n_vec = 0;
    int          n_bad = 0;
    int          exp_good = 0;
    int          exp_drop = 0;
    logic [15:0] exp_hop = 16'h0000;
    logic [7:0]  last_d = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    // Predicts outputs of a byte run whose first byte is sampled at edge e0.
    // ends=0 means the run is cut by reset, so the held byte never leaves.
    function automatic void model(input logic [7:0] b[$], input int e0, input bit ends);
        int n;
        int np;
        n = b.size();
        if (n == 0) return;
        if (n < 4 || b[0] != 8'h21 || b[1] != 8'h43) begin
            if (ends) exp_drop = sat(exp_drop);
            return;
        end
        hq.push_back('{e0 + 3, {b[3], b[2]}});
        exp_hop = {b[3], b[2]};
        np = n - 4;
        if (np > MAXP) begin
            for (int j = 0; j < MAXP; j++)
                pq.push_back('{e0 + 5 + j, b[4 + j], j == MAXP - 1, j == MAXP - 1});
            if (ends) exp_drop = sat(exp_drop);
        end else begin
            for (int j = 0; j < np; j++)
                if (ends || j < np - 1)
                    pq.push_back('{e0 + 5 + j, b[4 + j], ends && (j == np - 1), 1'b0});
            if (ends) exp_good = sat(exp_good);
        end
    endfunction

    initial begin
        pay_t p;
        hop_t h;
        forever begin
            @(negedge c);
            if (rst) begin
                last_d = 8'h00;
            end else begin
                if (payload_dv) begin
                    if (pq.size() == 0) begin
                        check("pay_unexpected", payload_d, 32'hFFFF);
                    end else begin
                        p = pq.pop_front();
                        check("pay_cycle", edges, p.stamp);
                        check("pay_data", payload_d, p.d);
                        check("pay_last", payload_last, p.last);
                        check("pay_err", payload_err, p.err);
                    end
                    last_d = payload_d;
                end else begin
                    check("pay_flags_idle", {payload_last, payload_err}, 0);
                    check("pay_hold", payload_d, last_d);
                end
                if (hop_count_valid) begin
                    if (hq.size() == 0) begin
                        check("hop_unexpected", hop_count, 32'hFFFFF);
                    end else begin
                        h = hq.pop_front();
                        check("hop_cycle", edges, h.stamp);
                        check("hop_value", hop_count, h.v);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [7:0] q[$]);
        for (int i = 0; i < q.size(); i++) begin
            rxd  = q[i];
            rxdv = 1'b1;
            @(posedge c); #1;
        end
    endtask

    // rst_at < 0: plain frame; otherwise reset is pulsed while byte rst_at is on the bus.
    task automatic send(input logic [7:0] q[$], input int rst_at);
        logic [7:0] pre[$];
        logic [7:0] rest[$];
        if (rst_at < 0) begin
            model(q, edges + 1, 1'b1);
            drive(q);
        end else begin
            for (int i = 0; i < rst_at; i++) pre.push_back(q[i]);
            for (int i = rst_at + 1; i < q.size(); i++) rest.push_back(q[i]);
            model(pre, edges + 1, 1'b0);
            drive(pre);
            rxd  = q[rst_at];
            rxdv = 1'b1;
            rst  = 1'b1;
            #1;
            pq.delete();
            hq.delete();
            exp_good = 0;
            exp_drop = 0;
            exp_hop  = 16'h0000;
            check("rst_flags", {payload_dv, payload_last, payload_err, hop_count_valid}, 0);
            check("rst_payload_d", payload_d, 0);
            check("rst_hop", hop_count, 0);
            check("rst_cnts", {good_cnt, drop_cnt}, 0);
            @(posedge c); #1;
            rst = 1'b0;
            model(rest, edges + 1, 1'b1);
            drive(rest);
        end
        rxdv = 1'b0;
        rxd  = 8'($urandom);
        repeat (3) begin @(posedge c); #1; end
        check("good_cnt", good_cnt, exp_good);
        check("drop_cnt", drop_cnt, exp_drop);
        check("hop_count", hop_count, exp_hop);
        check("pay_missing", pq.size(), 0);
        check("hop_missing", hq.size(), 0);
    endtask

    initial begin
        logic [7:0] f[$];
        int         kind, len;
        logic [7:0] bb;

        repeat (2) @(posedge c);
        #1;
        check("reset_flags", {payload_dv, payload_last, payload_err, hop_count_valid}, 0);
        check("reset_data", {hop_count, payload_d}, 0);
        check("reset_cnts", {good_cnt, drop_cnt}, 0);
        rst = 1'b0;

        f = {8'h21, 8'h43, 8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send(f, -1);
        f = {8'h21, 8'h44, 8'h05, 8'h00, 8'hAA};
        send(f, -1);
        f = {8'h21, 8'h43, 8'h07};
        send(f, -1);
        f = {8'h21, 8'h43, 8'h07, 8'h00};
        send(f, -1);
        f = {8'h21, 8'h43, 8'h34, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send(f, -1);
        f = {8'h21, 8'h43, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send(f, -1);
        f = {8'h21, 8'h43, 8'h09, 8'h00};
        for (int i = 0; i < 10; i++) f.push_back(8'(8'h80 + i));
        send(f, 5);
        for (int k = 0; k < 9; k++) begin
            f = {8'h21, 8'h40, 8'h01, 8'h00};
            send(f, -1);
        end

        for (int it = 0; it < 70; it++) begin
            f.delete();
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    do bb = 8'($urandom); while (bb == 8'h21);
                    f.push_back(bb);
                    len = $urandom_range(0, 5);
                    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
                end
                1: begin
                    do bb = 8'($urandom); while (bb == 8'h43);
                    f = {8'h21, bb};
                    len = $urandom_range(0, 6);
                    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
                end
                2: begin
                    f = {8'h21, 8'h43, 8'($urandom)};
                    len = $urandom_range(1, 3);
                    while (f.size() > len) void'(f.pop_back());
                end
                default: begin
                    f = {8'h21, 8'h43, 8'($urandom), 8'($urandom)};
                    len = $urandom_range(0, MAXP + 3);
                    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
                end
            endcase
            if (kind == 5 && f.size() > 2)
                send(f, $urandom_range(1, f.size() - 1));
            else
                send(f, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/udp_inbound_chain_rx.md
Name: udp_inbound_chain_rx

Overview:
Terminating receiver for the daisy-chain UDP protocol, at the last node of the chain. It parses each inbound chain frame: a 16-bit protocol version 0x4321 sent little-endian (0x21, 0x43), then a 16-bit little-endian hop count, then the payload. It latches the hop count and re-emits the payload as a framed byte stream with last/error flags for the local command decoder, and it keeps saturating good/drop frame counters.

Parameters:
MAX_PAYLOAD, 1472, maximum payload bytes accepted per frame; longer frames are truncated and flagged.
CNT_W, 16, width of the good/drop frame counters.

Ports:
c  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rxd  input  8  inbound byte
rxdv  input  1  byte valid; a frame is one contiguous run of rxdv=1, with at least 1 idle cycle between frames
hop_count  output  16  hop count of the most recent frame that reached the payload stage
hop_count_valid  output  1  one-cycle pulse when hop_count updates
payload_d  output  8  payload byte
payload_dv  output  1  payload byte valid
payload_last  output  1  qualifies payload_dv; final payload byte of the frame
payload_err  output  1  qualifies payload_last; frame exceeded MAX_PAYLOAD and was truncated
good_cnt  output  CNT_W  frames completed without error; saturates at all-ones
drop_cnt  output  CNT_W  frames rejected (bad version, runt, overflow); saturates at all-ones

Behaviour:
- Reset (async assert): state IDLE, hold register empty, all outputs 0 including hop_count and both counters.
- All outputs are registered.
- Header capture: the bytes are matched sequentially, not through a shift register.
- States and transitions, evaluated each cycle:
  - IDLE:
    - rxdv & rxd==0x21 -> VER_HI.
    - rxdv & other byte -> DISCARD, drop++.
  - VER_HI:
    - rxdv & rxd==0x43 -> HOP_LO.
    - rxdv & other byte -> DISCARD, drop++.
    - ~rxdv -> IDLE, drop++ (runt).
  - HOP_LO:
    - rxdv -> capture low byte, go to HOP_HI.
    - ~rxdv -> IDLE, drop++.
  - HOP_HI:
    - rxdv -> hop_count <= {rxd, low byte}, pulse hop_count_valid next cycle, go to PAYLOAD with byte count 0.
    - ~rxdv -> IDLE, drop++. hop_count is unchanged.
  - PAYLOAD:
    - rxdv & count<MAX_PAYLOAD -> if the hold register is full, emit the held byte with last=0; load rxd into the hold register; count++.
    - rxdv & count==MAX_PAYLOAD -> emit the held byte with last=1, err=1; drop++; go to DISCARD.
    - ~rxdv -> if the hold register is full, emit the held byte with last=1, err=0; good++; go to IDLE and clear the hold register.
  - DISCARD:
    - ~rxdv -> IDLE; rxdv -> stay. No outputs.
- Zero-payload frame (exactly 4 bytes): hop_count_valid pulses, good++, no payload_dv.
- Latency:
  - A payload byte on rxd in cycle n appears on payload_d in cycle n+2. Bytes are never reordered or duplicated.
  - payload_dv is never high more than once per input byte.
- hop_count_valid appears in cycle n+1 for a hop-high byte in cycle n.
- payload_last/payload_err are 0 whenever payload_dv=0. payload_d holds its last value when not valid.
- Counter updates take effect the cycle after the triggering event. A counter at all-ones stays there.
- Overflow: the byte count never exceeds MAX_PAYLOAD, so at most MAX_PAYLOAD bytes are emitted per frame.
- Reset asserted mid-frame: everything clears immediately and no payload_last is generated. If rxdv is still high after release, parsing restarts from IDLE on the next byte, and that byte must be 0x21 or the frame is discarded.
- No back-pressure: the downstream must accept one byte per cycle.

Test Plan:
1. Frame 21 43 05 00 AA BB CC, then idle -> hop_count=0x0005 with valid pulse 1 cycle after byte 00; payload AA,BB,CC each 2 cycles after input, last=1 on CC; good_cnt=1.
2. Frame 21 44 05 00 AA -> no payload_dv, no hop pulse; drop_cnt=1; next good frame parses normally.
3. Runt 21 43 07 (rxdv drops) -> drop_cnt=1, hop_count unchanged; the 4-byte frame 21 43 07 00 -> hop pulse 0x0007, no payload, good_cnt=1.
4. MAX_PAYLOAD=4, frame header + 6 payload bytes 01..06 -> payload 01..04 emitted, last=1 and err=1 on 04; 05/06 not emitted; drop_cnt=1, good_cnt=0.
5. Reset pulse on the 2nd payload byte of a 10-byte-payload frame -> all outputs 0 immediately, no last; remainder discarded; following frame correct.
6. CNT_W=2, 5 bad-version frames -> drop_cnt reads 1,2,3,3,3.
